rr_bus_responder: RTL and testbench
===================================

Name: rr_bus_responder

Overview:
- Responder end of the per-node request interface driven by the interconnect socket wrapper.
- Accepts one cache-to-cache transfer at a time from NUM_PROC sources and arbitrates round-robin.
- Holds the shared bus for a fixed transfer time, then delivers the address to the destination node as a one-cycle pulse.
- Runs on the divided interconnect clock.

Parameters:
- NUM_PROC, 4, number of nodes; must be ≥2.
- XFER_CYCLES, 4, bus-hold cycles per transfer; must be ≥1.
- ADDR_W, 48, address width.

Ports:
- clk  input  1  interconnect clock; rising-edge logic.
- rst_l  input  1  asynchronous active-low reset.
- request_in_avail  input  NUM_PROC  per-source level valid; held until consumed.
- addrs_in  input  NUM_PROC x ADDR_W  per-source address.
- request_dest  input  NUM_PROC x ($clog2(NUM_PROC)+1)  per-source destination node.
- processed_request  output  NUM_PROC  one-cycle pulse: source's current request consumed.
- request_out_avail  output  NUM_PROC  one-cycle pulse: delivery to node.
- addrs_out  output  NUM_PROC x ADDR_W  delivered address; valid while request_out_avail[i]=1, holds afterwards.
- bus_busy  output  1  high while in XFER.
- drop_err  output  1  one-cycle pulse: request with request_dest ≥ NUM_PROC consumed and discarded.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, cnt=0, rr_ptr=0.
  - processed_request, request_out_avail, bus_busy and drop_err are 0.
  - addrs_out is all 0.
  - An in-flight transfer is discarded; no delivery occurs after reset.
- All outputs are registered.
- processed_request, request_out_avail and drop_err default to 0 every cycle; they are single-cycle pulses.
- State IDLE:
  - If any request_in_avail bit is set, grant the first set bit at or after rr_ptr, cyclically.
  - Latch src, dest and addr; pulse processed_request[src].
  - rr_ptr <= (src+1) mod NUM_PROC.
  - If dest ≥ NUM_PROC: pulse drop_err and stay IDLE.
  - Otherwise: cnt <= XFER_CYCLES-1, bus_busy <= 1, go to XFER.
- State XFER:
  - If cnt ≠ 0: cnt decrements.
  - If cnt = 0: request_out_avail[dest] <= 1, addrs_out[dest] <= latched addr, bus_busy <= 0, go to IDLE.
  - request_in_avail is ignored.
- Latency: grant at edge E makes processed_request visible after E. Delivery is visible after edge E+XFER_CYCLES.
- The earliest next grant is edge E+XFER_CYCLES+1, so bus occupancy is XFER_CYCLES+1 cycles per transfer.
- A dropped request occupies 1 cycle; the next grant can occur at E+1.
- Source contract: after seeing processed_request[i], source i deasserts request_in_avail[i] or presents its next request before the next IDLE arbitration edge.
  - Because XFER_CYCLES ≥ 1, this is guaranteed except after a drop.
  - After a drop, an unchanged held request is treated as a new request; this is documented behaviour, not a bug.
- Self-transfer (src = dest) is legal and delivered normally.
- Sources with request_in_avail low are never granted.
- addrs_in and request_dest are sampled only on the grant edge; later changes do not affect the in-flight transfer.
- rr_ptr advances only on a grant, including a drop grant.
- Reset asserted mid-XFER forces the reset values immediately; a request held across reset is re-arbitrated from rr_ptr=0.

Decomposition:
- Shared package bus_pkg holds:
  - enum bus_state_t {IDLE, XFER};
  - packed struct xfer_t {src, dest, mem_address} with widths derived from NUM_PROC and ADDR_W;
  - localparam for the dest width $clog2(NUM_PROC)+1.
- One sub-module, rr_arbiter:
  - combinational, parameterised by NUM_PROC;
  - inputs: req vector and rr_ptr;
  - outputs: grant_valid and grant_idx.
- The responder owns the state, counter, pointer and output registers.

Test Plan (NUM_PROC=4, XFER_CYCLES=4, ADDR_W=48):
- Single transfer: src1 raises request_in_avail with addr=0x1234, dest=3 at edge 0.
  - processed_request=4'b0010 after edge 0.
  - bus_busy high for 4 cycles.
  - request_out_avail=4'b1000 and addrs_out[3]=0x1234 after edge 4, for exactly 1 cycle.
- Round-robin: all four sources hold requests (dest=(i+1)%4) from edge 0.
  - Grants occur in order 0,1,2,3 at edges 0,5,10,15.
  - Deliveries reach nodes 1,2,3,0 after edges 4,9,14,19.
  - Each processed_request is one pulse.
- Fairness wrap: sources 3 and 0 both request after the last grant went to source 2.
  - Source 3 is granted first, then source 0.
- Invalid destination: src2, dest=4, addr=0xAA.
  - processed_request[2] and drop_err pulse together; no request_out_avail.
  - bus_busy stays 0; a pending src3 request is granted at the next edge.
- Reset mid-transfer: rst_l driven low 2 cycles after a grant, while XFER is active.
  - All outputs are 0 immediately; no delivery ever appears for the discarded transfer.
  - After release, a held src0 request is re-granted and delivered 4 edges later.
- Self-send plus input change: src0→dest0 addr=0x55, with addrs_in[0] changed to 0x99 on the cycle after the grant.
  - addrs_out[0]=0x55 with request_out_avail[0] pulse.

Source files
------------

// File: rtl/bus_pkg.sv
//==============================================================================
// Package  : bus_pkg
// Shared types and widths for the round-robin bus responder.
// Revision : 1.0
//==============================================================================
`default_nettype none

package bus_pkg;

    localparam int unsigned BUS_NUM_PROC = 4;
    localparam int unsigned BUS_ADDR_W   = 48;
    localparam int unsigned BUS_SRC_W    = $clog2(BUS_NUM_PROC);
    // One extra bit so out-of-range destinations can be represented and dropped
    localparam int unsigned BUS_DEST_W   = $clog2(BUS_NUM_PROC) + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } bus_state_t;

    // Sized for the default build; widen the package localparams when the
    // responder is instantiated with more nodes or a wider address.
    typedef struct packed {
        logic [BUS_SRC_W-1:0]  src;
        logic [BUS_DEST_W-1:0] dest;
        logic [BUS_ADDR_W-1:0] mem_address;
    } xfer_t;

    function automatic int unsigned dest_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//==============================================================================
// Module   : rr_arbiter
// Combinational round-robin pick: first set request at or after the pointer.
// Revision : 1.0
//==============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int unsigned NUM_PROC = 4
) (
    input  logic [NUM_PROC-1:0]         i_req,
    input  logic [$clog2(NUM_PROC)-1:0] i_rr_ptr,
    output logic                        o_grant_valid,
    output logic [$clog2(NUM_PROC)-1:0] o_grant_idx
);

    localparam int unsigned c_idx_w = $clog2(NUM_PROC);

    int unsigned w_idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        o_grant_valid = 1'b0;
        o_grant_idx   = '0;
        w_idx         = 0;
        for (int k = NUM_PROC - 1; k >= 0; k--) begin
            w_idx = (int'(i_rr_ptr) + k) % NUM_PROC;
            if (i_req[w_idx]) begin
                o_grant_valid = 1'b1;
                o_grant_idx   = c_idx_w'(w_idx);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rr_bus_responder.sv
//==============================================================================
// Module   : rr_bus_responder
// Arbitrates cache-to-cache transfers, holds the bus, then delivers a pulse.
// Revision : 1.0
//==============================================================================
`default_nettype none

module rr_bus_responder
    import bus_pkg::*;
#(
    parameter int unsigned NUM_PROC    = BUS_NUM_PROC,
    parameter int unsigned XFER_CYCLES = 4,
    parameter int unsigned ADDR_W      = BUS_ADDR_W
) (
    input  logic                                       clk,
    input  logic                                       rst_l,
    input  logic [NUM_PROC-1:0]                        request_in_avail,
    input  logic [NUM_PROC-1:0][ADDR_W-1:0]            addrs_in,
    input  logic [NUM_PROC-1:0][$clog2(NUM_PROC):0]    request_dest,
    output logic [NUM_PROC-1:0]                        processed_request,
    output logic [NUM_PROC-1:0]                        request_out_avail,
    output logic [NUM_PROC-1:0][ADDR_W-1:0]            addrs_out,
    output logic                                       bus_busy,
    output logic                                       drop_err
);

    localparam int unsigned c_idx_w  = $clog2(NUM_PROC);
    localparam int unsigned c_dest_w = dest_width(NUM_PROC);
    localparam int unsigned c_cnt_w  = $clog2(XFER_CYCLES + 1);

    localparam logic [c_idx_w-1:0]  c_last_idx   = c_idx_w'(NUM_PROC - 1);
    localparam logic [c_dest_w-1:0] c_num_proc_d = c_dest_w'(NUM_PROC);
    localparam logic [c_cnt_w-1:0]  c_cnt_init   = c_cnt_w'(XFER_CYCLES - 1);

    bus_state_t                      state_q, state_d;
    logic [c_cnt_w-1:0]              cnt_q, cnt_d;
    logic [c_idx_w-1:0]              rr_ptr_q, rr_ptr_d;
    xfer_t                           xfer_q, xfer_d;
    logic [NUM_PROC-1:0]             processed_request_q, processed_request_d;
    logic [NUM_PROC-1:0]             request_out_avail_q, request_out_avail_d;
    logic [NUM_PROC-1:0][ADDR_W-1:0] addrs_out_q, addrs_out_d;
    logic                            bus_busy_q, bus_busy_d;
    logic                            drop_err_q, drop_err_d;

    logic                            w_grant_valid;
    logic [c_idx_w-1:0]              w_grant_idx;
    logic                            w_unused;

    rr_arbiter #(
        .NUM_PROC (NUM_PROC)
    ) u_arb (
        .i_req         (request_in_avail),
        .i_rr_ptr      (rr_ptr_q),
        .o_grant_valid (w_grant_valid),
        .o_grant_idx   (w_grant_idx)
    );

    always_comb begin
        state_d             = state_q;
        cnt_d               = cnt_q;
        rr_ptr_d            = rr_ptr_q;
        xfer_d              = xfer_q;
        addrs_out_d         = addrs_out_q;
        bus_busy_d          = bus_busy_q;
        processed_request_d = '0;
        request_out_avail_d = '0;
        drop_err_d          = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_grant_valid) begin
                    xfer_d.src                       = w_grant_idx;
                    xfer_d.dest                      = request_dest[w_grant_idx];
                    xfer_d.mem_address               = addrs_in[w_grant_idx];
                    processed_request_d[w_grant_idx] = 1'b1;
                    rr_ptr_d = (w_grant_idx == c_last_idx) ? '0
                                                           : w_grant_idx + c_idx_w'(1);
                    // Out-of-range destinations are consumed without using the bus
                    if (request_dest[w_grant_idx] >= c_num_proc_d) begin
                        drop_err_d = 1'b1;
                    end else begin
                        cnt_d      = c_cnt_init;
                        bus_busy_d = 1'b1;
                        state_d    = XFER;
                    end
                end
            end
            XFER: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - c_cnt_w'(1);
                end else begin
                    request_out_avail_d[xfer_q.dest[c_idx_w-1:0]] = 1'b1;
                    addrs_out_d[xfer_q.dest[c_idx_w-1:0]]         = xfer_q.mem_address;
                    bus_busy_d                                    = 1'b0;
                    state_d                                       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q             <= IDLE;
            cnt_q               <= '0;
            rr_ptr_q            <= '0;
            xfer_q              <= '0;
            processed_request_q <= '0;
            request_out_avail_q <= '0;
            addrs_out_q         <= '0;
            bus_busy_q          <= 1'b0;
            drop_err_q          <= 1'b0;
        end else begin
            state_q             <= state_d;
            cnt_q               <= cnt_d;
            rr_ptr_q            <= rr_ptr_d;
            xfer_q              <= xfer_d;
            processed_request_q <= processed_request_d;
            request_out_avail_q <= request_out_avail_d;
            addrs_out_q         <= addrs_out_d;
            bus_busy_q          <= bus_busy_d;
            drop_err_q          <= drop_err_d;
        end
    end

    assign processed_request = processed_request_q;
    assign request_out_avail = request_out_avail_q;
    assign addrs_out         = addrs_out_q;
    assign bus_busy          = bus_busy_q;
    assign drop_err          = drop_err_q;

    // Source id and the range bit of dest are kept for debug visibility only
    assign w_unused = ^{xfer_q.src, xfer_q.dest[c_dest_w-1]};

endmodule

`default_nettype wire

// File: tb/tb_rr_bus_responder.sv
//==============================================================================
// Module   : tb_rr_bus_responder
// Self-checking bench with a delivery scoreboard for rr_bus_responder.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_rr_bus_responder;

    localparam int NP = 4;
    localparam int XC = 4;
    localparam int AW = 48;

    logic                     clk;
    logic                     rst_l;
    logic [NP-1:0]            request_in_avail;
    logic [NP-1:0][AW-1:0]    addrs_in;
    logic [NP-1:0][2:0]       request_dest;
    logic [NP-1:0]            processed_request;
    logic [NP-1:0]            request_out_avail;
    logic [NP-1:0][AW-1:0]    addrs_out;
    logic                     bus_busy;
    logic                     drop_err;

    typedef struct {
        int           node;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    rr_bus_responder #(
        .NUM_PROC    (NP),
        .XFER_CYCLES (XC),
        .ADDR_W      (AW)
    ) dut (
        .clk               (clk),
        .rst_l             (rst_l),
        .request_in_avail  (request_in_avail),
        .addrs_in          (addrs_in),
        .request_dest      (request_dest),
        .processed_request (processed_request),
        .request_out_avail (request_out_avail),
        .addrs_out         (addrs_out),
        .bus_busy          (bus_busy),
        .drop_err          (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [2:0] d);
        request_in_avail[i] = 1'b1;
        addrs_in[i]         = a;
        request_dest[i]     = d;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pr"},   64'(processed_request), 64'h0);
        chk({tag, "_out"},  64'(request_out_avail), 64'h0);
        chk({tag, "_busy"}, 64'(bus_busy), 64'h0);
        chk({tag, "_drop"}, 64'(drop_err), 64'h0);
        chk({tag, "_addr"}, 64'(addrs_out != '0), 64'h0);
    endtask

    // Grant on the next edge, bus held XC cycles, delivery pulse on edge E+XC.
    task automatic do_xfer(input int src, input int dest, input logic [AW-1:0] addr);
        tick();
        chk("grant_pr",   64'(processed_request), 64'(1 << src));
        chk("grant_busy", 64'(bus_busy), 64'h1);
        chk("grant_out",  64'(request_out_avail), 64'h0);
        chk("grant_drop", 64'(drop_err), 64'h0);
        sb.push_back('{dest, addr});
        request_in_avail[src] = 1'b0;
        addrs_in[src]         = 48'h99;
        request_dest[src]     = 3'((dest + 1) % NP);
        repeat (XC - 1) begin
            tick();
            chk("hold_busy", 64'(bus_busy), 64'h1);
            chk("hold_pr",   64'(processed_request), 64'h0);
            chk("hold_out",  64'(request_out_avail), 64'h0);
        end
        tick();
        chk("dlv_out",  64'(request_out_avail), 64'(1 << dest));
        chk("dlv_addr", 64'(addrs_out[dest]), 64'(addr));
        chk("dlv_busy", 64'(bus_busy), 64'h0);
        chk("dlv_pr",   64'(processed_request), 64'h0);
    endtask

    // Scoreboard: every delivery pulse must match the oldest expected transfer.
    always @(negedge clk) begin
        if (rst_l && request_out_avail != '0) begin
            for (int i = 0; i < NP; i++) begin
                if (request_out_avail[i]) begin
                    if (sb.size() == 0) begin
                        chk("sb_unexpected_node", 64'(i), 64'hFFFF);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("sb_node", 64'(i), 64'(e.node));
                        chk("sb_addr", 64'(addrs_out[i]), 64'(e.addr));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_l            = 1'b0;
        request_in_avail = '0;
        addrs_in         = '0;
        request_dest     = '0;
        repeat (2) tick();
        chk_zero("reset");
        rst_l = 1'b1;
        tick();

        // Single transfer src1 -> node3
        set_req(1, 48'h1234, 3'd3);
        do_xfer(1, 3, 48'h1234);
        tick();
        chk("single_pulse_end", 64'(request_out_avail), 64'h0);
        chk("single_addr_hold", 64'(addrs_out[3]), 64'h1234);

        // Round-robin from a fresh pointer
        rst_l = 1'b0;
        #2;
        chk_zero("rst2");
        tick();
        rst_l = 1'b1;
        for (int i = 0; i < NP; i++) set_req(i, 48'h100 + 48'(i), 3'((i + 1) % NP));
        for (int g = 0; g < NP; g++) do_xfer(g, (g + 1) % NP, 48'h100 + 48'(g));
        tick();

        // Fairness wrap: after src2, src3 beats src0
        set_req(2, 48'h200, 3'd1);
        do_xfer(2, 1, 48'h200);
        set_req(3, 48'h300, 3'd0);
        set_req(0, 48'h301, 3'd2);
        do_xfer(3, 0, 48'h300);
        do_xfer(0, 2, 48'h301);
        tick();

        // Invalid destination is dropped; pending src3 granted next edge
        set_req(2, 48'hAA, 3'd4);
        set_req(3, 48'h3AA, 3'd1);
        tick();
        chk("drop_pr",   64'(processed_request), 64'b0100);
        chk("drop_err",  64'(drop_err), 64'h1);
        chk("drop_busy", 64'(bus_busy), 64'h0);
        chk("drop_out",  64'(request_out_avail), 64'h0);
        request_in_avail[2] = 1'b0;
        do_xfer(3, 1, 48'h3AA);
        tick();

        // Reset two cycles into a transfer discards it
        set_req(0, 48'h500, 3'd3);
        tick();
        chk("mid_pr",   64'(processed_request), 64'b0001);
        chk("mid_busy", 64'(bus_busy), 64'h1);
        repeat (2) tick();
        #2;
        rst_l = 1'b0;
        #1;
        chk_zero("midrst");
        set_req(1, 48'h511, 3'd2);
        tick();
        chk_zero("inrst");
        rst_l = 1'b1;
        do_xfer(0, 3, 48'h500);
        do_xfer(1, 2, 48'h511);
        tick();

        // Self-send with address changing after the grant
        set_req(0, 48'h55, 3'd0);
        do_xfer(0, 0, 48'h55);

        repeat (XC + 2) tick();
        chk("idle_busy", 64'(bus_busy), 64'h0);
        chk("sb_empty",  64'(sb.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
